// File: rtl/game_sprite_loader.sv
// Sprite update loader: buffers a header plus optional row words from a
// valid/ready stream and commits them to the display registers during vblank.
module game_sprite_loader #(
    parameter int unsigned X_WIDTH         = 10,
    parameter int unsigned Y_WIDTH         = 10,
    parameter int unsigned SPRITE_HEIGHT   = 8,
    parameter int unsigned ROW_INDEX_WIDTH = 3,
    parameter int unsigned ROW_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROW_WIDTH-1:0]       in_data,
    input  logic                       vblank,
    output logic                       busy,
    output logic                       done,
    output logic                       xy_we,
    output logic                       row_we,
    output logic [ROW_INDEX_WIDTH-1:0] wr_row_index,
    output logic [ROW_WIDTH-1:0]       wr_data
);

    localparam int unsigned ROWS_FOLLOW_BIT = 29;
    localparam logic [ROW_INDEX_WIDTH-1:0] LAST_ROW = ROW_INDEX_WIDTH'(SPRITE_HEIGHT - 1);

    // x and y must stay clear of the enable/tile/rows_follow flag bits
    if (X_WIDTH + Y_WIDTH > 29) begin : g_xy_too_wide
        $error("game_sprite_loader: X_WIDTH + Y_WIDTH must not exceed 29");
    end

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RECV_ROWS   = 3'd1,
        WAIT_VB     = 3'd2,
        COMMIT_ROWS = 3'd3,
        COMMIT_XY   = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic [ROW_INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic [ROW_WIDTH-1:0]       hdr_q, hdr_d;
    logic [ROW_WIDTH-1:0]       shadow_q [SPRITE_HEIGHT];

    logic                       in_ready_q, in_ready_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       xy_we_q, xy_we_d;
    logic                       row_we_q, row_we_d;
    logic [ROW_INDEX_WIDTH-1:0] wr_row_index_q, wr_row_index_d;
    logic [ROW_WIDTH-1:0]       wr_data_q, wr_data_d;

    logic accept;
    logic shadow_we;

    assign accept    = in_valid && in_ready_q;
    assign shadow_we = accept && (state_q == RECV_ROWS);

    // State register; outputs are registered from the next-state decode so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            hdr_q          <= '0;
            in_ready_q     <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            xy_we_q        <= 1'b0;
            row_we_q       <= 1'b0;
            wr_row_index_q <= '0;
            wr_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hdr_q          <= hdr_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            xy_we_q        <= xy_we_d;
            row_we_q       <= row_we_d;
            wr_row_index_q <= wr_row_index_d;
            wr_data_q      <= wr_data_d;
        end
    end

    // Shadow rows carry no reset; a discarded update is never committed.
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_q[cnt_q] <= in_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    hdr_d   = in_data;
                    cnt_d   = '0;
                    state_d = in_data[ROWS_FOLLOW_BIT] ? RECV_ROWS : WAIT_VB;
                end
            end
            RECV_ROWS: begin
                if (accept) begin
                    if (cnt_q == LAST_ROW) begin
                        cnt_d   = '0;
                        state_d = WAIT_VB;
                    end else begin
                        cnt_d = cnt_q + ROW_INDEX_WIDTH'(1);
                    end
                end
            end
            WAIT_VB: begin
                if (vblank) begin
                    state_d = hdr_q[ROWS_FOLLOW_BIT] ? COMMIT_ROWS : COMMIT_XY;
                end
            end
            COMMIT_ROWS: begin
                if (cnt_q == LAST_ROW) begin
                    cnt_d   = '0;
                    state_d = COMMIT_XY;
                end else begin
                    cnt_d = cnt_q + ROW_INDEX_WIDTH'(1);
                end
            end
            COMMIT_XY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state and row counter only
    always_comb begin
        in_ready_d     = 1'b0;
        busy_d         = 1'b0;
        done_d         = 1'b0;
        xy_we_d        = 1'b0;
        row_we_d       = 1'b0;
        wr_row_index_d = '0;
        wr_data_d      = '0;
        unique case (state_d)
            IDLE: begin
                in_ready_d = 1'b1;
            end
            RECV_ROWS: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            WAIT_VB: begin
                busy_d = 1'b1;
            end
            COMMIT_ROWS: begin
                busy_d         = 1'b1;
                row_we_d       = 1'b1;
                wr_row_index_d = cnt_d;
                wr_data_d      = shadow_q[cnt_d];
            end
            COMMIT_XY: begin
                busy_d    = 1'b1;
                xy_we_d   = 1'b1;
                done_d    = 1'b1;
                wr_data_d = hdr_d;
            end
            default: begin
                in_ready_d = 1'b0;
            end
        endcase
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign xy_we        = xy_we_q;
    assign row_we       = row_we_q;
    assign wr_row_index = wr_row_index_q;
    assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_game_sprite_loader.sv
// Scoreboard bench for game_sprite_loader: each update pushes its expected
// write sequence; a monitor pops and compares every row/xy write.
module tb_game_sprite_loader;

    localparam int unsigned H = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        vblank;
    logic        busy;
    logic        done;
    logic        xy_we;
    logic        row_we;
    logic [2:0]  wr_row_index;
    logic [31:0] wr_data;

    game_sprite_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .vblank       (vblank),
        .busy         (busy),
        .done         (done),
        .xy_we        (xy_we),
        .row_we       (row_we),
        .wr_row_index (wr_row_index),
        .wr_data      (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_xy;
        logic [2:0]  idx;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;
    int  cyc = 0;
    int  acc_cyc = 0;
    int  last_xy_cyc = 0;
    int  done_cnt = 0;
    bit  rand_vb = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: samples 1 time unit after each edge, when outputs have settled.
    bit prev_wr = 1'b0, prev_xy = 1'b0, prev_ready = 1'b1, burst_open = 1'b0;
    always @(posedge clk) begin
        wr_t e;
        bit  wr;
        #1;
        if (!reset) begin
            prev_wr = 1'b0; prev_xy = 1'b0; prev_ready = 1'b1; burst_open = 1'b0;
        end else begin
            wr = xy_we || row_we;
            chk(!(xy_we && row_we), "we_exclusive", {30'b0, xy_we, row_we}, 32'h0);
            chk(done == xy_we, "done_with_xy", 32'(done), 32'(xy_we));
            if (!wr) chk(wr_data == 32'h0, "idle_wr_data", wr_data, 32'h0);
            if (burst_open) chk(wr, "burst_contiguous", 32'(wr), 32'h1);
            if (prev_xy) chk(in_ready, "ready_after_xy", 32'(in_ready), 32'h1);
            if (wr && !burst_open) begin
                chk(vblank, "commit_starts_in_vblank", 32'(vblank), 32'h1);
                chk(!prev_ready && !prev_wr, "wait_vb_precedes_commit", {30'b0, prev_ready, prev_wr}, 32'h0);
            end
            if (wr) begin
                chk(!in_ready, "ready_low_in_commit", 32'(in_ready), 32'h0);
                chk(exp_q.size() > 0, "unexpected_write", {wr_data}, 32'h0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk(e.is_xy == xy_we, "write_kind", 32'(xy_we), 32'(e.is_xy));
                    if (row_we) chk(wr_row_index == e.idx, "row_index", 32'(wr_row_index), 32'(e.idx));
                    chk(wr_data == e.data, "write_data", wr_data, e.data);
                end
            end
            if (done) done_cnt++;
            if (xy_we) last_xy_cyc = cyc;
            burst_open = row_we;
            prev_wr = wr; prev_xy = xy_we; prev_ready = in_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        if (rand_vb) vblank = ($urandom_range(0, 3) == 0);
    endtask

    // Drives one word; returns at the following negedge with in_valid low.
    task automatic send_word(input logic [31:0] w, input int gap);
        int n = 0;
        for (int g = 0; g < gap; g++) begin in_valid = 1'b0; tick(); end
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 200) begin tick(); n++; end
        chk(in_ready, "ready_wait", 32'(in_ready), 32'h1);
        if (in_ready) begin
            @(posedge clk); #1;
            acc_cyc = cyc;
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Reference model: rows 0..H-1 in order when rows_follow, then the header.
    task automatic send_update(input logic [31:0] hdr, input logic [31:0] rows [H], input int gmin, input int gmax);
        if (hdr[29]) for (int i = 0; i < H; i++) exp_q.push_back({1'b0, 3'(i), rows[i]});
        exp_q.push_back({1'b1, 3'b0, hdr});
        send_word(hdr, int'($urandom_range(gmin, gmax)));
        if (hdr[29]) for (int i = 0; i < H; i++) send_word(rows[i], int'($urandom_range(gmin, gmax)));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
        chk(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'h0);
        tick(); tick();
    endtask

    // Asserts reset at the current negedge for one edge and checks reset values.
    task automatic apply_reset();
        reset = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk({busy, done, xy_we, row_we} == 4'b0, "reset_flags", {28'b0, busy, done, xy_we, row_we}, 32'h0);
        chk(wr_row_index == 3'd0 && wr_data == 32'h0, "reset_data", wr_data | 32'(wr_row_index), 32'h0);
        tick();
        reset = 1'b1;
        @(posedge clk); #1;
        chk(in_ready, "ready_after_reset", 32'(in_ready), 32'h1);
        tick();
    endtask

    function automatic logic [31:0] mk_hdr(input bit en, input bit rows, input int x, input int y);
        logic [31:0] h = '0;
        h[31]    = en;
        h[29]    = rows;
        h[19:10] = 10'(x);
        h[9:0]   = 10'(y);
        return h;
    endfunction

    initial begin
        logic [31:0] rows [H];
        logic [31:0] h;
        int          n;
        int          d0;

        reset = 1'b0; in_valid = 1'b0; in_data = '0; vblank = 1'b0;
        tick(); tick();
        apply_reset();

        // Header-only with vblank already high: 3 cycles accept-to-xy inclusive.
        vblank = 1'b1;
        h = mk_hdr(1'b1, 1'b0, 100, 50);
        send_update(h, rows, 0, 0);
        drain();
        chk(last_xy_cyc - acc_cyc + 2 == 1 + 1 + 0 + 1, "latency_hdr_only", 32'(last_xy_cyc - acc_cyc + 2), 32'd3);

        // Full update held off by 20 cycles of active display.
        rows = '{32'h000cc000, 32'h00cccc00, 32'h0cccccc0, 32'hcccccccc,
                 32'hcccccccc, 32'h0cccccc0, 32'h00cccc00, 32'hcccccccc};
        vblank = 1'b0;
        send_update(mk_hdr(1'b1, 1'b1, 320, 200), rows, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk(!in_ready && !row_we && !xy_we, "quiet_while_waiting", {29'b0, in_ready, row_we, xy_we}, 32'h0);
        end
        vblank = 1'b1;
        drain();

        // Back-pressure: one idle cycle before every word; vblank high throughout.
        for (int i = 0; i < H; i++) rows[i] = $urandom;
        send_update(mk_hdr(1'b0, 1'b1, 7, 9) | 32'h4000_0000, rows, 1, 1);
        drain();
        chk(last_xy_cyc - acc_cyc + 2 == 1 + 1 + int'(H) + 1, "latency_rows", 32'(last_xy_cyc - acc_cyc + 2), 32'd11);

        // vblank drops during the second row write; burst must still complete.
        for (int i = 0; i < H; i++) rows[i] = $urandom;
        send_update(mk_hdr(1'b1, 1'b1, 1, 2), rows, 0, 0);
        n = 0;
        while (!(row_we && wr_row_index == 3'd1) && n < 50) begin tick(); n++; end
        chk(row_we && wr_row_index == 3'd1, "reach_row1", 32'(wr_row_index), 32'd1);
        vblank = 1'b0;
        drain();
        vblank = 1'b1;

        // Reset during RECV_ROWS with four rows taken; nothing may commit.
        vblank = 1'b0;
        send_word(mk_hdr(1'b1, 1'b1, 11, 12), 0);
        for (int i = 0; i < 4; i++) send_word($urandom, 0);
        apply_reset();
        vblank = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Reset during the commit at row index 3.
        for (int i = 0; i < H; i++) rows[i] = $urandom;
        send_update(mk_hdr(1'b1, 1'b1, 13, 14), rows, 0, 0);
        n = 0;
        while (!(row_we && wr_row_index == 3'd3) && n < 50) begin tick(); n++; end
        chk(row_we && wr_row_index == 3'd3, "reach_row3", 32'(wr_row_index), 32'd3);
        d0 = done_cnt;
        apply_reset();
        for (int i = 0; i < 12; i++) tick();
        chk(done_cnt == d0, "no_done_after_reset", 32'(done_cnt), 32'(d0));
        send_update(mk_hdr(1'b1, 1'b0, 500, 400), rows, 0, 0);
        drain();

        // Three header-only updates back to back.
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) send_update(mk_hdr(1'b1, 1'b0, 10 * i, 20 * i), rows, 0, 0);
        drain();
        chk(done_cnt == d0 + 3, "three_done", 32'(done_cnt - d0), 32'd3);

        // Randomized updates with random gaps and random vblank.
        rand_vb = 1'b1;
        for (int u = 0; u < 25; u++) begin
            for (int i = 0; i < H; i++) rows[i] = $urandom;
            h = $urandom;
            send_update(h, rows, 0, 2);
        end
        drain();
        rand_vb = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
